// File: rtl/sha256_message_padder.sv
// sha256_message_padder
//   Turns a 32-bit message word stream into padded 512-bit SHA-256 blocks.
//   It adds the 0x80 marker byte, the zero fill and the 64-bit big-endian
//   message bit length, so the hashing engine downstream only ever sees
//   complete blocks.
//
// Ports
//   clk             clock
//   sync_rst        synchronous active-high reset
//   data_in         message word, byte 0 in [31:24]
//   data_in_nbytes  valid bytes in the last word (0..4, 5..7 read as 4)
//   data_in_last    final word of the message
//   data_in_valid   input word valid
//   data_in_ready   word accepted this cycle (high only while collecting)
//   data_out        padded block, word 0 in [511:480], word 15 in [31:0]
//   data_out_last   final block of the message
//   data_out_valid  block valid
//   data_out_ready  downstream accepts the block
//
// State | meaning
//   COLLECT | accepting message words into blk[idx]
//   PAD     | message complete, writing marker / zero fill / length
//   EMIT    | presenting blk downstream, waiting for data_out_ready
module sha256_message_padder #(
  parameter int BYTECNTWIDTH = 32,
  parameter int BLOCKWIDTH   = 512
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic [31:0]           data_in,
  input  logic [2:0]            data_in_nbytes,
  input  logic                  data_in_last,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [BLOCKWIDTH-1:0] data_out,
  output logic                  data_out_last,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  if (BLOCKWIDTH != 512) begin : g_bad_width
    $error("sha256_message_padder: BLOCKWIDTH must be 512");
  end

  typedef enum logic [1:0] {COLLECT, PAD, EMIT} state_t;

  state_t                  state, state_nxt;
  logic [31:0]             blk [16];
  logic [3:0]              idx;
  logic [BYTECNTWIDTH-1:0] byte_cnt;
  logic                    pad_placed;
  logic                    tail;
  logic                    final_blk;

  logic                    accept;
  logic [2:0]              nb;
  logic [63:0]             bit_len;
  logic                    wr_en;
  logic [31:0]             wr_data;
  logic                    len_wr;

  assign accept  = data_in_valid & (state == COLLECT);
  assign nb      = (data_in_nbytes > 3'd4) ? 3'd4 : data_in_nbytes;
  assign bit_len = 64'({byte_cnt, 3'b000});

  // Keep the first n bytes of the last word, put the 0x80 marker right
  // behind them and zero the rest.
  function automatic logic [31:0] last_word(input logic [31:0] w, input logic [2:0] n);
    case (n)
      3'd0:    return 32'h8000_0000;
      3'd1:    return {w[31:24], 24'h80_0000};
      3'd2:    return {w[31:16], 16'h8000};
      3'd3:    return {w[31:8], 8'h80};
      default: return w;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (sync_rst) state <= COLLECT;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept) begin
        if (idx == 4'd15)      state_nxt = EMIT;
        else if (data_in_last) state_nxt = PAD;
      end
      PAD: if ((pad_placed && idx == 4'd14) || idx == 4'd15) state_nxt = EMIT;
      EMIT: if (data_out_ready) begin
        if (final_blk)  state_nxt = COLLECT;
        else if (tail)  state_nxt = PAD;
        else            state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Outputs
  always_comb begin
    data_in_ready  = (state == COLLECT);
    data_out_valid = (state == EMIT);
    data_out_last  = (state == EMIT) && final_blk;
    data_out       = '0;
    for (int i = 0; i < 16; i++) data_out[BLOCKWIDTH-1-32*i -: 32] = blk[i];
  end

  // Block write decode
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    len_wr  = 1'b0;
    case (state)
      COLLECT: if (accept) begin
        wr_en   = 1'b1;
        wr_data = data_in_last ? last_word(data_in, nb) : data_in;
      end
      PAD: begin
        if (!pad_placed) begin
          wr_en   = 1'b1;
          wr_data = 32'h8000_0000;
        end else if (idx == 4'd14) begin
          len_wr  = 1'b1;
        end else begin
          wr_en   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Block storage has no reset; its contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (len_wr) begin
      blk[14] <= bit_len[63:32];
      blk[15] <= bit_len[31:0];
    end else if (wr_en) begin
      blk[idx] <= wr_data;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      idx        <= '0;
      byte_cnt   <= '0;
      pad_placed <= 1'b0;
      tail       <= 1'b0;
      final_blk  <= 1'b0;
    end else begin
      case (state)
        COLLECT: if (accept) begin
          idx <= idx + 4'd1;
          if (data_in_last) begin
            byte_cnt   <= byte_cnt + BYTECNTWIDTH'(nb);
            pad_placed <= (nb != 3'd4);
            tail       <= 1'b1;
          end else begin
            byte_cnt   <= byte_cnt + BYTECNTWIDTH'(4);
          end
        end
        PAD: begin
          if (!pad_placed) begin
            pad_placed <= 1'b1;
            idx        <= idx + 4'd1;
          end else if (idx == 4'd14) begin
            final_blk  <= 1'b1;
          end else begin
            idx        <= idx + 4'd1;
          end
        end
        EMIT: if (data_out_ready) begin
          idx <= '0;
          if (final_blk) begin
            byte_cnt   <= '0;
            tail       <= 1'b0;
            pad_placed <= 1'b0;
            final_blk  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
